// File: rtl/rf_pkg.sv
// Shared constants and the register-address type for the scoreboarded register file.
package rf_pkg;

  localparam int XLEN_DEFAULT  = 32;
  localparam int NREGS_DEFAULT = 32;
  localparam int AW_DEFAULT    = $clog2(NREGS_DEFAULT);

  typedef logic [AW_DEFAULT-1:0] reg_addr_t;

endpackage

// File: rtl/scoreboard_register_file_if.sv
// Read ports, two writeback ports, issue port and scoreboard status of the register file.
interface scoreboard_register_file_if import rf_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
);

  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                wb0_en;
  logic [AW-1:0]       wb0_addr;
  logic [XLEN-1:0]     wb0_data;
  logic                wb1_en;
  logic [AW-1:0]       wb1_addr;
  logic [XLEN-1:0]     wb1_data;
  logic                issue_en;
  logic [AW-1:0]       issue_addr;
  logic [NREGS-1:0]    busy_vec;
  logic                hazard;

  modport master (
    output raddr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           issue_en, issue_addr,
    input  rdata, rbusy, busy_vec, hazard
  );

  modport slave (
    input  raddr, wb0_en, wb0_addr, wb0_data, wb1_en, wb1_addr, wb1_data,
           issue_en, issue_addr,
    output rdata, rbusy, busy_vec, hazard
  );

endinterface

// File: rtl/rf_scoreboard.sv
// Pending-writeback bit per register: set by issue, cleared by either writeback port.
module rf_scoreboard import rf_pkg::*; #(
  parameter int NREGS = NREGS_DEFAULT,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_issue_en,
  input  logic [AW-1:0]    i_issue_addr,
  input  logic             i_wb0_en,
  input  logic [AW-1:0]    i_wb0_addr,
  input  logic             i_wb1_en,
  input  logic [AW-1:0]    i_wb1_addr,
  output logic [NREGS-1:0] o_busy_vec
);

  logic [NREGS-1:0] r_busy;
  logic [NREGS-1:0] w_busyNext;

  // Set is applied after the clears: an issue in the same cycle is the newer producer.
  always_comb begin
    w_busyNext = r_busy;
    if (i_wb0_en && (i_wb0_addr != '0)) w_busyNext[i_wb0_addr] = 1'b0;
    if (i_wb1_en && (i_wb1_addr != '0)) w_busyNext[i_wb1_addr] = 1'b0;
    if (i_issue_en && (i_issue_addr != '0)) w_busyNext[i_issue_addr] = 1'b1;
    w_busyNext[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busyNext;
  end

  assign o_busy_vec = r_busy;

endmodule

// File: rtl/scoreboard_register_file.sv
// Register file with x0 hardwired to zero, write-through bypass on every read port
// and a pending-writeback scoreboard for hazard detection.
module scoreboard_register_file import rf_pkg::*; #(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int NREGS = NREGS_DEFAULT,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input logic clk,
  input logic rst,
  scoreboard_register_file_if.slave bus
);

  logic [XLEN-1:0]  r_regs [NREGS];
  logic [NREGS-1:0] w_busyVec;
  logic             w_wb0Ok;
  logic             w_wb1Ok;

  assign w_wb0Ok = bus.wb0_en && (bus.wb0_addr != '0);
  assign w_wb1Ok = bus.wb1_en && (bus.wb1_addr != '0);

  // wb1 is written last so it wins a same-address collision.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int n = 0; n < NREGS; n++) r_regs[n] <= '0;
    end else begin
      if (w_wb0Ok) r_regs[bus.wb0_addr] <= bus.wb0_data;
      if (w_wb1Ok) r_regs[bus.wb1_addr] <= bus.wb1_data;
    end
  end

  rf_scoreboard #(.NREGS(NREGS)) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .i_issue_en   (bus.issue_en),
    .i_issue_addr (bus.issue_addr),
    .i_wb0_en     (bus.wb0_en),
    .i_wb0_addr   (bus.wb0_addr),
    .i_wb1_en     (bus.wb1_en),
    .i_wb1_addr   (bus.wb1_addr),
    .o_busy_vec   (w_busyVec)
  );

  for (genvar g = 0; g < NRD; g++) begin : g_rdPort
    logic [AW-1:0] w_addr;
    logic          w_hit0;
    logic          w_hit1;

    assign w_addr = bus.raddr[g*AW +: AW];
    assign w_hit0 = w_wb0Ok && (bus.wb0_addr == w_addr);
    assign w_hit1 = w_wb1Ok && (bus.wb1_addr == w_addr);

    // A write landing this cycle both forwards its data and retires the pending flag.
    assign bus.rdata[g*XLEN +: XLEN] = (w_addr == '0) ? '0 :
                                       w_hit1         ? bus.wb1_data :
                                       w_hit0         ? bus.wb0_data :
                                                        r_regs[w_addr];
    assign bus.rbusy[g] = w_busyVec[w_addr] & ~(w_hit0 | w_hit1);
  end

  assign bus.busy_vec = w_busyVec;
  assign bus.hazard   = |bus.rbusy;

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Self-checking bench: a reference model plus directed expectations feed a queue
// that is drained and compared against the DUT once per cycle.
module tb_scoreboard_register_file;
  import rf_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  scoreboard_register_file_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) bus ();

  scoreboard_register_file #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t            expQ[$];
  int              checks = 0;
  int              errors = 0;
  logic [XLEN-1:0] mRegs [NREGS];
  logic [NREGS-1:0] mBusy;
  bit              modelValid = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // sel: 0..NRD-1 rdata, 10+i rbusy, 20 hazard, 30 busy_vec, 100+n busy_vec[n]
  function automatic logic [63:0] getObs(input int sel);
    logic [63:0] v;
    v = '0;
    if (sel < NRD)                          v[XLEN-1:0] = bus.rdata[sel*XLEN +: XLEN];
    else if (sel >= 10 && sel < 10 + NRD)   v[0] = bus.rbusy[sel-10];
    else if (sel == 20)                     v[0] = bus.hazard;
    else if (sel == 30)                     v[NREGS-1:0] = bus.busy_vec;
    else if (sel >= 100 && sel < 100+NREGS) v[0] = bus.busy_vec[sel-100];
    else                                    v = 64'hBAD0_BAD0_BAD0_BAD0;
    return v;
  endfunction

  task automatic expectValue(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input logic r,
                               input logic ie, input logic [AW-1:0] ia,
                               input logic w0e, input logic [AW-1:0] w0a, input logic [XLEN-1:0] w0d,
                               input logic w1e, input logic [AW-1:0] w1a, input logic [XLEN-1:0] w1d,
                               input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    rst            = r;
    bus.issue_en   = ie;
    bus.issue_addr = ia;
    bus.wb0_en     = w0e;
    bus.wb0_addr   = w0a;
    bus.wb0_data   = w0d;
    bus.wb1_en     = w1e;
    bus.wb1_addr   = w1a;
    bus.wb1_data   = w1d;
    bus.raddr      = {ra1, ra0};
  endtask

  task automatic idle(input logic [AW-1:0] ra0, input logic [AW-1:0] ra1);
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, ra0, ra1);
  endtask

  task automatic pushModel();
    logic [AW-1:0]   a;
    logic [XLEN-1:0] d;
    logic            h0, h1, b;
    logic            hz;
    hz = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      a  = bus.raddr[p*AW +: AW];
      h0 = bus.wb0_en && (bus.wb0_addr == a) && (a != '0);
      h1 = bus.wb1_en && (bus.wb1_addr == a) && (a != '0);
      if (a == '0)  d = '0;
      else if (h1)  d = bus.wb1_data;
      else if (h0)  d = bus.wb0_data;
      else          d = mRegs[a];
      b  = mBusy[a] && !(h0 || h1);
      hz = hz | b;
      expectValue($sformatf("model_rdata%0d", p), p, {32'h0, d});
      expectValue($sformatf("model_rbusy%0d", p), 10 + p, {63'h0, b});
    end
    expectValue("model_hazard", 20, {63'h0, hz});
    expectValue("model_busy_vec", 30, {32'h0, mBusy});
  endtask

  task automatic updateModel();
    if (rst) begin
      for (int n = 0; n < NREGS; n++) mRegs[n] = '0;
      mBusy      = '0;
      modelValid = 1;
    end else begin
      if (bus.wb0_en && bus.wb0_addr != '0) begin
        mRegs[bus.wb0_addr] = bus.wb0_data;
        mBusy[bus.wb0_addr] = 1'b0;
      end
      if (bus.wb1_en && bus.wb1_addr != '0) begin
        mRegs[bus.wb1_addr] = bus.wb1_data;
        mBusy[bus.wb1_addr] = 1'b0;
      end
      if (bus.issue_en && bus.issue_addr != '0) mBusy[bus.issue_addr] = 1'b1;
    end
  endtask

  task automatic runCycle();
    exp_t e;
    if (modelValid) pushModel();
    @(negedge clk);
    while (expQ.size() > 0) begin
      e = expQ.pop_front();
      checkOutput(e.tag, getObs(e.sel), e.exp);
    end
    @(posedge clk);
    updateModel();
    #1;
  endtask

  initial begin
    logic [AW-1:0] rA0, rA1, iA, wA0, wA1;
    idle('0, '0);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, '0, '0);
    runCycle();
    runCycle();
    idle(5'd5, 5'd9);
    expectValue("post_reset_rdata0", 0, 64'h0);
    expectValue("post_reset_rdata1", 1, 64'h0);
    expectValue("post_reset_hazard", 20, 64'h0);
    runCycle();

    // Reset clears stored data
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 5'd0, 5'd0);
    runCycle();
    idle(5'd5, 5'd0);
    expectValue("x5_written", 0, 64'hDEADBEEF);
    runCycle();
    applyStimulus(1'b1, 1'b0, '0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd5, 5'd0);
    runCycle();
    idle(5'd5, 5'd0);
    expectValue("x5_after_reset", 0, 64'h0);
    expectValue("busy_after_reset", 30, 64'h0);
    runCycle();

    // Bypass
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd7, 32'h12345678, 1'b0, '0, '0, 5'd7, 5'd0);
    expectValue("bypass_same_cycle", 0, 64'h12345678);
    runCycle();
    for (int k = 0; k < 2; k++) begin
      idle(5'd7, 5'd0);
      expectValue("bypass_later", 0, 64'h12345678);
      runCycle();
    end

    // Write-write collision
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd3, 32'hAAAA, 1'b1, 5'd3, 32'h5555, 5'd3, 5'd3);
    expectValue("collision_bypass", 0, 64'h5555);
    runCycle();
    idle(5'd3, 5'd0);
    expectValue("collision_stored", 0, 64'h5555);
    runCycle();

    // x0 stays zero and never busy
    applyStimulus(1'b0, 1'b1, 5'd0, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd0);
    runCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, '0, '0, 5'd0, 5'd0);
    expectValue("x0_busy_after_issue", 100, 64'h0);
    expectValue("x0_write_bypass", 0, 64'h0);
    runCycle();
    idle(5'd0, 5'd0);
    expectValue("x0_read", 0, 64'h0);
    expectValue("x0_busy", 100, 64'h0);
    runCycle();

    // Scoreboard set/clear on x9
    applyStimulus(1'b0, 1'b1, 5'd9, 1'b0, '0, '0, 1'b0, '0, '0, 5'd0, 5'd9);
    runCycle();
    idle(5'd0, 5'd9);
    expectValue("x9_busy_t1", 109, 64'h1);
    expectValue("x9_rbusy1_t1", 11, 64'h1);
    expectValue("x9_hazard_t1", 20, 64'h1);
    runCycle();
    idle(5'd0, 5'd9);
    runCycle();
    applyStimulus(1'b0, 1'b0, '0, 1'b0, '0, '0, 1'b1, 5'd9, 32'h0000_0099, 5'd0, 5'd9);
    expectValue("x9_rbusy1_wb", 11, 64'h0);
    expectValue("x9_rdata1_wb", 1, 64'h99);
    runCycle();
    idle(5'd0, 5'd9);
    expectValue("x9_busy_t4", 109, 64'h0);
    runCycle();

    // Issue/writeback race leaves the bit set
    applyStimulus(1'b0, 1'b1, 5'd4, 1'b1, 5'd4, 32'h44, 1'b0, '0, '0, 5'd4, 5'd0);
    runCycle();
    idle(5'd4, 5'd0);
    expectValue("x4_race_busy", 104, 64'h1);
    expectValue("x4_race_data", 0, 64'h44);
    runCycle();

    // Reset overrides same-cycle issue and writeback
    applyStimulus(1'b1, 1'b1, 5'd6, 1'b1, 5'd6, 32'h66, 1'b0, '0, '0, 5'd6, 5'd4);
    runCycle();
    idle(5'd6, 5'd4);
    expectValue("rst_override_data", 0, 64'h0);
    expectValue("rst_override_busy", 30, 64'h0);
    expectValue("rst_override_hazard", 20, 64'h0);
    runCycle();

    // Random traffic on a narrow address range to force frequent overlaps
    for (int k = 0; k < 80; k++) begin
      rA0 = AW'($urandom_range(0, 7));
      rA1 = AW'($urandom_range(0, 7));
      iA  = AW'($urandom_range(0, 7));
      wA0 = AW'($urandom_range(0, 7));
      wA1 = AW'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 24) == 0),
                    1'($urandom_range(0, 1)), iA,
                    1'($urandom_range(0, 1)), wA0, $urandom,
                    1'($urandom_range(0, 1)), wA1, $urandom,
                    rA0, rA1);
      runCycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001: Parameter XLEN, 32, register data width in bits.
REQ-002: Parameter NREGS, 32, number of architectural registers (power of two, at least 2).
REQ-003: Parameter NRD, 2, number of read ports (1 to 4).
REQ-004: Derived localparam AW = $clog2(NREGS), register address width.
REQ-005: clk  input  1  single clock, all state updates on rising edge.
REQ-006: rst  input  1  reset, synchronous and active-high.
REQ-007: raddr  input  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-008: rdata  output  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
REQ-009: rbusy  output  NRD  per-port pending-writeback flag.
REQ-010: wb0_en / wb0_addr / wb0_data  input  1 / AW / XLEN  write port 0 (ALU writeback).
REQ-011: wb1_en / wb1_addr / wb1_data  input  1 / AW / XLEN  write port 1 (load writeback).
REQ-012: issue_en / issue_addr  input  1 / AW  mark the destination register of an issued instruction as pending.
REQ-013: busy_vec  output  NREGS  registered scoreboard, bit n = register n pending.
REQ-014: hazard  output  1  high when any rbusy bit is high.

Function
REQ-015: Register 0 SHALL always read zero; writes to it are discarded; busy_vec[0] SHALL be constant 0.
REQ-016: Reads SHALL be combinational with zero-cycle latency from raddr to rdata.
REQ-017: Write-through bypass: a read of register n in the same cycle as an enabled write to n SHALL return that cycle's write data.
REQ-018: Write-write collision: when wb0 and wb1 are both enabled to the same nonzero address, wb1 SHALL win for both the stored value and the bypass.
REQ-019: Writes SHALL commit on the rising edge; storage holds the value until the next write.
REQ-020: Scoreboard set: issue_en with nonzero issue_addr SHALL set busy_vec[issue_addr] on the next edge.
REQ-021: Scoreboard clear: each enabled writeback with a nonzero address SHALL clear that busy bit on the next edge.
REQ-022: Simultaneous issue and writeback to the same register SHALL leave the bit set, because the issue is a newer producer.
REQ-023: rbusy[i] SHALL equal busy_vec[raddr_i] AND NOT (an enabled write to raddr_i this cycle).
REQ-024: A write to a register whose busy bit is clear SHALL be legal and SHALL update data only.
REQ-025: Out-of-range addresses SHALL NOT occur because NREGS is a power of two; no wrap logic is required.

Reset
REQ-026: While rst is high at a rising edge, all registers SHALL become 0 and busy_vec SHALL become all-zero.
REQ-027: rst SHALL override issue and writeback in the same cycle; no state carries over.
REQ-028: In the first cycle after reset deasserts, rdata SHALL be 0 on all ports (unless bypassed) and hazard SHALL be 0.

Structure
REQ-029: Shared package rf_pkg SHALL hold the default XLEN/NREGS constants and a typedef for the register address.
REQ-030: The scoreboard SHALL be a sub-module rf_scoreboard (inputs: issue and both writebacks; output: busy_vec); the data array and bypass muxes SHALL stay in the top module.
REQ-031: Read-port logic SHALL be produced by a generate loop over NRD, with no per-port hand-copied code.

Verification
REQ-032: Reset check: write 0xDEADBEEF to x5, then assert rst for 1 cycle, then read x5 -> 0, busy_vec = 0.
REQ-033: Bypass check: wb0 writes 0x12345678 to x7 while raddr0 = 7 in the same cycle -> rdata0 = 0x12345678 in that cycle and on every later cycle.
REQ-034: Collision check: wb0 writes 0xAAAA to x3 and wb1 writes 0x5555 to x3 in the same cycle -> read x3 = 0x5555.
REQ-035: x0 check: issue x0, then write 0xFFFFFFFF to x0 -> read x0 = 0, busy_vec[0] = 0.
REQ-036: Scoreboard check: issue x9 at cycle t -> busy_vec[9] = 1 at t+1, and raddr1 = 9 gives rbusy[1] = 1 and hazard = 1; wb1 writes x9 at t+3 -> rbusy[1] = 0 in that cycle and busy_vec[9] = 0 at t+4.
REQ-037: Issue/writeback race: issue x4 and wb0 to x4 in the same cycle -> busy_vec[4] = 1 on the next cycle.
